// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen -- I2S bit clock / word select generator.
//
// Divides clk_i down to a bit clock (bclk_o) and generates the word select
// (ws_o) with a configurable number of bits per channel. A stop request lets
// the current frame finish (ending after the right channel) before going idle.
//
// Ports:
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   cfg_div_i        BCLK half-period in clk_i cycles, minus 1
//   cfg_bits_i       bits per channel, minus 1
//   start_i, stop_i  single-cycle run control (stop wins when both are high)
//   busy_o           high while running or finishing a frame
//   bclk_o, ws_o     registered bit clock (idles low) and word select (0 = left)
//   bclk_rise_o      high in the first cycle bclk_o is 1
//   bclk_fall_o      high in the first cycle bclk_o is 0 after being 1
//   frame_start_o    high in the first cycle of a left channel
//
// Optional feature: define I2S_CLK_GEN_CFG_SHADOW_EN to re-latch the config
// inputs at every frame start while running (new values apply to that frame).
module i2s_clk_gen #(
  parameter int DIV_WIDTH  = 8,
  parameter int BITS_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [BITS_WIDTH-1:0] cfg_bits_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  busy_o,
  output logic                  bclk_o,
  output logic                  ws_o,
  output logic                  bclk_rise_o,
  output logic                  bclk_fall_o,
  output logic                  frame_start_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_div, r_div_cnt;
  logic [BITS_WIDTH-1:0] r_bits, r_bit_cnt;
  logic                  r_busy, r_bclk, r_ws, r_rise, r_fall, r_fs;

  logic w_tick, w_fall, w_wrap, w_frame_end, w_resume, w_stay;

  assign w_tick      = (r_div_cnt == r_div);
  assign w_fall      = w_tick & r_bclk;
  assign w_wrap      = w_fall & (r_bit_cnt == r_bits);
  assign w_frame_end = w_wrap & r_ws;   // ws about to go 1->0
  assign w_resume    = start_i & ~stop_i;
  // Whether the block keeps running across a frame boundary this cycle.
  assign w_stay      = ((r_state == S_RUN)  & ~stop_i) |
                       ((r_state == S_STOP) & w_resume);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bits    <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_bclk    <= 1'b0;
      r_ws      <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_fs   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            r_div     <= cfg_div_i;
            r_bits    <= cfg_bits_i;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_ws      <= 1'b0;
            r_busy    <= 1'b1;
            r_fs      <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN, S_STOP: begin
          if (w_frame_end && !w_stay) begin
            // Frame complete while stopping: drop straight to idle. The
            // final falling edge gets no strobe since we are now idle.
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_ws      <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            if (w_tick) begin
              r_div_cnt <= '0;
              r_bclk    <= ~r_bclk;
              r_rise    <= ~r_bclk;
              r_fall    <= r_bclk;
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_wrap) begin
              r_bit_cnt <= '0;
              r_ws      <= ~r_ws;
            end else if (w_fall) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_frame_end) begin
              r_fs <= 1'b1;
`ifdef I2S_CLK_GEN_CFG_SHADOW_EN
              // Divider is being cleared this cycle, so the new values
              // govern the whole of the frame that starts here.
              r_div  <= cfg_div_i;
              r_bits <= cfg_bits_i;
`else
              // Config held from start; inputs ignored while busy.
`endif
            end
            if (r_state == S_RUN && stop_i)
              r_state <= S_STOP;
            else if (r_state == S_STOP && w_resume)
              r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign bclk_o        = r_bclk;
  assign ws_o          = r_ws;
  assign bclk_rise_o   = r_rise;
  assign bclk_fall_o   = r_fall;
  assign frame_start_o = r_fs;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Scoreboard bench for i2s_clk_gen: stimulus pushes expected frame_start_o
// and busy_o-fall cycle numbers; a negedge monitor pops and compares them
// whenever the DUT presents those events. Directed spot checks cover the
// bclk/ws waveform, reset behaviour and idle behaviour.
module tb_i2s_clk_gen;
  localparam int DW = 8;
  localparam int BW = 6;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [DW-1:0] cfg_div_i = '0;
  logic [BW-1:0] cfg_bits_i = '0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          busy_o, bclk_o, ws_o, bclk_rise_o, bclk_fall_o, frame_start_o;

  i2s_clk_gen #(.DIV_WIDTH(DW), .BITS_WIDTH(BW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_div_i(cfg_div_i), .cfg_bits_i(cfg_bits_i),
    .start_i(start_i), .stop_i(stop_i), .busy_o(busy_o), .bclk_o(bclk_o), .ws_o(ws_o),
    .bclk_rise_o(bclk_rise_o), .bclk_fall_o(bclk_fall_o), .frame_start_o(frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int fs_q[$];   // expected frame_start_o cycles
  int bf_q[$];   // expected busy_o 1->0 cycles
  int n_fall = 0, last_rise = 0, rise_per = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (frame_start_o) begin
        if (fs_q.size() == 0) chk("fs_unexpected", cyc, -1);
        else chk("fs_cycle", cyc, fs_q.pop_front());
      end
      if (prev_busy && !busy_o) begin
        if (bf_q.size() == 0) chk("busy_fall_unexpected", cyc, -1);
        else chk("busy_fall_cycle", cyc, bf_q.pop_front());
      end
      if (!busy_o) chk("idle_strobe", int'({bclk_rise_o, bclk_fall_o, frame_start_o}), 0);
      if (bclk_rise_o) begin
        rise_per  = cyc - last_rise;
        last_rise = cyc;
      end
      if (bclk_fall_o) n_fall++;
      prev_busy = busy_o;
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #3;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_run(input int div, input int bits, output int c0);
    cfg_div_i  = DW'(div);
    cfg_bits_i = BW'(bits);
    start_i    = 1'b1;
    c0         = cyc + 1;
    fs_q.push_back(c0);
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  initial begin
    int c, f0, drops;

    // Reset state
    tick(2);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_bclk", int'(bclk_o), 0);
    chk("rst_ws", int'(ws_o), 0);
    chk("rst_strobes", int'({bclk_rise_o, bclk_fall_o, frame_start_o}), 0);
    rst_n_i = 1'b1;
    tick(3);
    chk("post_rst_idle", int'(busy_o), 0);

    // start+stop together in IDLE, and stop alone: no effect
    cfg_div_i = 8'd1; cfg_bits_i = 6'd3;
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    tick(5);
    chk("both_busy", int'(busy_o), 0);
    chk("both_bclk", int'(bclk_o), 0);
    pulse_stop();
    tick(2);
    chk("stop_idle_busy", int'(busy_o), 0);

    // div=1, bits=3: BCLK period 4, ws every 16, frame 32
    start_run(1, 3, c);
    fs_q.push_back(c + 32);
    fs_q.push_back(c + 64);
    chk("c_busy", int'(busy_o), 1);
    chk("c_ws0", int'(ws_o), 0);
    wait_until(c + 1);
    chk("c_bclk_low", int'(bclk_o), 0);
    f0 = n_fall;
    wait_until(c + 2);
    chk("c_bclk_rise", int'(bclk_o), 1);
    chk("c_rise_strobe", int'(bclk_rise_o), 1);
    wait_until(c + 15);
    chk("c_ws_left", int'(ws_o), 0);
    wait_until(c + 16);
    chk("c_ws_right", int'(ws_o), 1);
    chk("c_fall_strobe", int'(bclk_fall_o), 1);
    wait_until(c + 17);
    chk("c_falls_per_ch", n_fall - f0, 4);
    wait_until(c + 24);
    chk("c_bclk_period", rise_per, 4);
    wait_until(c + 70);
    pulse_stop();
    bf_q.push_back(c + 96);
    wait_until(c + 95);
    chk("c_busy_stopping", int'(busy_o), 1);
    wait_until(c + 96);
    chk("c_end_bclk", int'(bclk_o), 0);
    chk("c_end_ws", int'(ws_o), 0);
    tick(4);

    // div=0, bits=31: stop 10 cycles into left, frame of 128
    start_run(0, 31, c);
    wait_until(c + 10);
    pulse_stop();
    bf_q.push_back(c + 128);
    wait_until(c + 64);
    chk("d_ws_right", int'(ws_o), 1);
    wait_until(c + 127);
    chk("d_busy_last", int'(busy_o), 1);
    wait_until(c + 128);
    chk("d_end_busy", int'(busy_o), 0);
    chk("d_end_bclk", int'(bclk_o), 0);
    chk("d_end_ws", int'(ws_o), 0);
    tick(4);

    // STOPPING then resume: busy never drops, frames keep period 32
    start_run(1, 3, c);
    fs_q.push_back(c + 32);
    fs_q.push_back(c + 64);
    wait_until(c + 5);
    pulse_stop();
    wait_until(c + 20);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    drops = 0;
    while (cyc < c + 70) begin
      if (!busy_o) drops++;
      tick();
    end
    chk("e_busy_drops", drops, 0);
    pulse_stop();
    bf_q.push_back(c + 96);
    wait_until(c + 100);

    // Reset mid-frame: immediate, then restart with ws=0
    start_run(1, 3, c);
    wait_until(c + 18);
    chk("f_pre_bclk", int'(bclk_o), 1);
    chk("f_pre_ws", int'(ws_o), 1);
    rst_n_i = 1'b0;
    #1;
    chk("f_rst_busy", int'(busy_o), 0);
    chk("f_rst_bclk", int'(bclk_o), 0);
    chk("f_rst_ws", int'(ws_o), 0);
    chk("f_rst_strobes", int'({bclk_rise_o, bclk_fall_o, frame_start_o}), 0);
    tick(2);
    rst_n_i = 1'b1;
    tick(2);
    start_run(1, 3, c);
    chk("f_restart_ws", int'(ws_o), 0);
    chk("f_restart_busy", int'(busy_o), 1);
    pulse_stop();
    bf_q.push_back(c + 32);
    wait_until(c + 36);

    // Config change mid-frame: div 1 -> 3
    start_run(1, 3, c);
    fs_q.push_back(c + 32);
    wait_until(c + 10);
    cfg_div_i = 8'd3;
    wait_until(c + 30);
    chk("g_old_period", rise_per, 4);
    wait_until(c + 40);
    pulse_stop();
`ifdef I2S_CLK_GEN_CFG_SHADOW_EN
    bf_q.push_back(c + 96);
    wait_until(c + 60);
    chk("g_new_period", rise_per, 8);
`else
    bf_q.push_back(c + 64);
    wait_until(c + 60);
    chk("g_new_period", rise_per, 4);
`endif
    wait_until(c + 100);
    chk("g_end_busy", int'(busy_o), 0);

    tick(2);
    chk("fs_q_drained", fs_q.size(), 0);
    chk("bf_q_drained", bf_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/i2s_clk_gen.md
I2S_CLK_GEN -- requirements
Module: i2s_clk_gen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8: width of the BCLK divider field.
REQ-002 SHALL have parameter BITS_WIDTH, default 6: width of the bits-per-channel field.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port cfg_div_i  input  DIV_WIDTH  BCLK half-period in clk_i cycles, minus 1.
REQ-006 SHALL have port cfg_bits_i  input  BITS_WIDTH  bits per channel, minus 1.
REQ-007 SHALL have port start_i  input  1  single-cycle start request.
REQ-008 SHALL have port stop_i  input  1  single-cycle stop request.
REQ-009 SHALL have port busy_o  output  1  high in RUN or STOPPING.
REQ-010 SHALL have port bclk_o  output  1  registered bit clock; idles low.
REQ-011 SHALL have port ws_o  output  1  registered word select; 0 = left, 1 = right.
REQ-012 SHALL have port bclk_rise_o  output  1  strobe, high in the first cycle bclk_o is 1.
REQ-013 SHALL have port bclk_fall_o  output  1  strobe, high in the first cycle bclk_o is 0 after being 1.
REQ-014 SHALL have port frame_start_o  output  1  strobe marking the start of a left channel.

Function
REQ-015 SHALL implement the states IDLE, RUN and STOPPING.
REQ-016 IDLE, start_i=1 and stop_i=0: SHALL latch cfg_div_i and cfg_bits_i, clear the divider and bit counters, set ws_o=0, go to RUN, and assert busy_o and frame_start_o in the next cycle.
REQ-017 IDLE, start_i and stop_i both 1: SHALL remain in IDLE (stop wins).
REQ-018 RUN/STOPPING: the divider SHALL count 0..div, and on reaching div SHALL clear and toggle bclk_o; BCLK period = 2*(div+1) clk_i cycles.
REQ-019 The first bclk_o rise SHALL occur (div+1) cycles after busy_o asserts.
REQ-020 Each BCLK falling edge SHALL increment the bit counter.
REQ-021 When the bit counter equals bits, the falling edge SHALL instead wrap the counter to 0 and toggle ws_o in the same cycle.
REQ-022 A ws_o 1->0 toggle in RUN SHALL pulse frame_start_o for one cycle, aligned with bclk_fall_o.
REQ-023 RUN with stop_i=1 SHALL go to STOPPING; start_i in RUN SHALL be ignored.
REQ-024 STOPPING with start_i=1 SHALL return to RUN without disturbing the counters, bclk_o or ws_o.
REQ-025 STOPPING SHALL run to the end of the current frame.
REQ-026 At the falling edge where ws_o would go 1->0, STOPPING SHALL go to IDLE with bclk_o=0, ws_o=0, busy_o=0 and no frame_start_o pulse.
REQ-027 stop_i in IDLE SHALL have no effect.
REQ-028 Stop latency SHALL be at most one frame: 2*(bits+1)*2*(div+1) clk_i cycles.
REQ-029 Strobes SHALL never be asserted in IDLE.
REQ-030 Counters SHALL be sized so that div = 2^DIV_WIDTH-1 and bits = 2^BITS_WIDTH-1 operate without overflow.

Reset
REQ-031 rst_n_i low SHALL immediately force IDLE, clear both counters and the latched config, and drive busy_o, bclk_o, ws_o, bclk_rise_o, bclk_fall_o and frame_start_o to 0.
REQ-032 Reset asserted mid-frame SHALL abort without completing the frame.
REQ-033 After reset deasserts, the block SHALL wait in IDLE for start_i.

Configuration
REQ-034 With macro I2S_CLK_GEN_CFG_SHADOW_EN defined, cfg_div_i and cfg_bits_i SHALL also be re-latched at every frame_start_o event in RUN, taking effect from that frame's first bit.
REQ-035 Without I2S_CLK_GEN_CFG_SHADOW_EN, config SHALL be latched only at start from IDLE, and input changes while busy SHALL be ignored.

Verification
REQ-036 div=1, bits=3, start pulse -> BCLK period 4 cycles; ws_o toggles every 16 cycles; frame_start_o every 32 cycles; 4 bclk_fall_o per channel.
REQ-037 div=0, bits=31, stop_i at 10 cycles into the left channel -> busy_o stays high until the right channel completes (frame of 128 cycles); then bclk_o=0, ws_o=0, busy_o=0, with no trailing frame_start_o.
REQ-038 STOPPING then start_i before frame end -> busy_o never drops; frame_start_o continues with period 32 (div=1, bits=3).
REQ-039 start_i and stop_i together in IDLE -> busy_o stays 0 and bclk_o stays 0.
REQ-040 rst_n_i low mid-frame -> all outputs 0 in the same cycle, without waiting for a clock edge; a new start after release restarts with ws_o=0.
REQ-041 SHADOW_EN: change div 1->3 mid-frame -> the old period of 4 is kept until the next frame_start_o, then the period is 8. Without SHADOW_EN, the period stays 4.
